// File: rtl/rlc_pio_bidir_if.sv
// rtl/rlc_pio_bidir_if.sv - Avalon-MM slave bus bundle for the bidirectional PIO
// Fixed 3-bit word address, 32-bit data, read latency 1, no waitrequest.
interface rlc_pio_bidir_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/rlc_pio_bidir.sv
// rtl/rlc_pio_bidir.sv - parametrised bidirectional PIO with set/clear, edge capture and irq
// Pins are synchronised through s1/s2, with s3 as history for edge detection.
module rlc_pio_bidir #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET  = '0,
  parameter logic [DATA_WIDTH-1:0] DIR_RESET  = '0,
  parameter int                    EDGE_TYPE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  rlc_pio_bidir_if.slave        bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);
  localparam int W = DATA_WIDTH;

  logic [W-1:0] data_out_q, data_out_d;
  logic [W-1:0] dir_q, dir_d;
  logic [W-1:0] irqmask_q, irqmask_d;
  logic [W-1:0] edgecap_q, edgecap_d;
  logic [W-1:0] s1_q, s2_q, s3_q;
  logic [1:0]   prime_q, prime_d;
  logic [31:0]  readdata_q, readdata_d;

  logic         wr_en, rd_en;
  logic [W-1:0] wdata, clr, det;
  logic [31:0]  rd_mux;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;
  assign wdata = bus.writedata[W-1:0];

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irqmask_d  = irqmask_q;
    clr        = '0;
    if (wr_en) begin
      case (bus.address)
        3'd0: data_out_d = wdata;
        3'd1: dir_d      = wdata;
        3'd2: irqmask_d  = wdata;
        3'd3: clr        = wdata;
        3'd4: data_out_d = data_out_q | wdata;
        3'd5: data_out_d = data_out_q & ~wdata;
        default: ;
      endcase
    end
  end

  // Detection stays off until the synchroniser has been primed, so pins high at reset are not edges.
  always_comb begin
    det = '0;
    if (prime_q == 2'd3) begin
      if (EDGE_TYPE == 0)      det = s2_q & ~s3_q;
      else if (EDGE_TYPE == 1) det = ~s2_q & s3_q;
      else                     det = s2_q ^ s3_q;
    end
    edgecap_d = (edgecap_q & ~clr) | det;
    prime_d   = (prime_q == 2'd3) ? 2'd3 : prime_q + 2'd1;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0: rd_mux[W-1:0] = (dir_q & data_out_q) | (~dir_q & s2_q);
      3'd1: rd_mux[W-1:0] = dir_q;
      3'd2: rd_mux[W-1:0] = irqmask_q;
      3'd3: rd_mux[W-1:0] = edgecap_q;
      default: ;
    endcase
    readdata_d = rd_en ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= OUT_RESET;
      dir_q      <= DIR_RESET;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      prime_q    <= 2'd0;
      readdata_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      s1_q       <= in_port;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      prime_q    <= prime_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port     = data_out_q;
  assign out_en       = dir_q;
  assign bus.readdata = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);
endmodule
